// File: rtl/ecc_frame_sequencer.sv
// Frame sequencer/checker in front of the NB-LDPC decoder: beat-wise frame load,
// decoder launch with timeout, lane-parallel compare against reference, error statistics.
module ecc_frame_sequencer #(
    parameter int SYMBOL_NUM     = 288,
    parameter int INFO_NUM       = 256,
    parameter int FIELD          = 3,
    parameter int LLR_BIT        = 3,
    parameter int SYMBOL_BIT     = 3,
    parameter int LANES          = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BIT        = 16,
    localparam int SE_W          = $clog2(INFO_NUM + 1)
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 IN_VALID,
    output logic                                 IN_READY,
    input  logic [LANES*FIELD*LLR_BIT-1:0]       IN_LLR,
    input  logic [LANES*SYMBOL_BIT-1:0]          IN_REF,
    input  logic                                 CLR_STATS,
    output logic [SYMBOL_NUM*FIELD*LLR_BIT-1:0]  DEC_INPUT_LLR,
    output logic [INFO_NUM*SYMBOL_BIT-1:0]       DEC_INPUT_SYMBOL,
    output logic                                 DEC_ENABLE,
    input  logic                                 DEC_READY,
    input  logic [INFO_NUM*SYMBOL_BIT-1:0]       DEC_OUTPUT_SYMBOL,
    output logic                                 RES_VALID,
    output logic [SE_W-1:0]                      RES_SYM_ERR,
    output logic                                 RES_FRAME_ERR,
    output logic                                 RES_TIMEOUT,
    output logic [CNT_BIT-1:0]                   FRAME_CNT,
    output logic [CNT_BIT-1:0]                   FAIL_CNT,
    output logic                                 BUSY
);

    localparam int BEAT_LLR_W = LANES * FIELD * LLR_BIT;
    localparam int BEAT_REF_W = LANES * SYMBOL_BIT;
    localparam int SYM_BEATS  = SYMBOL_NUM / LANES;
    localparam int INFO_BEATS = INFO_NUM / LANES;
    localparam int BEAT_W     = (SYM_BEATS > 1) ? $clog2(SYM_BEATS) : 1;
    localparam int TMO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SYM_BEATS - 1);
    localparam logic [BEAT_W-1:0] INFO_LAST = BEAT_W'(INFO_BEATS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SE_W-1:0]   SE_ALL    = SE_W'(INFO_NUM);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_DECODE, S_COMPARE, S_REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [SE_W-1:0]     acc_q, acc_d;
    logic [SE_W-1:0]     res_sym_q, res_sym_d;
    logic                res_ferr_q, res_ferr_d;
    logic                res_tmo_q, res_tmo_d;
    logic [CNT_BIT-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_BIT-1:0]  fail_cnt_q, fail_cnt_d;
    logic                rdy_s_q, rdy_p_q;

    logic [SYMBOL_NUM*FIELD*LLR_BIT-1:0] llr_buf_q;
    logic [INFO_NUM*SYMBOL_BIT-1:0]      ref_buf_q;
    logic [INFO_NUM*SYMBOL_BIT-1:0]      cap_q;

    logic                  accept;
    logic                  rdy_edge;
    logic                  cap_en;
    logic [31:0]           llr_base;
    logic [31:0]           ref_base;
    logic [BEAT_REF_W-1:0] cap_beat;
    logic [BEAT_REF_W-1:0] ref_beat;
    logic [SE_W-1:0]       lane_mis;
    logic [SE_W-1:0]       acc_sum;

    // Gated by RST so the bench-visible handshake is closed while reset is held.
    assign IN_READY   = RST & ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign accept     = IN_VALID & IN_READY;
    assign DEC_ENABLE = (state_q == S_LAUNCH) || (state_q == S_DECODE);
    assign BUSY       = (state_q != S_IDLE);
    assign RES_VALID  = (state_q == S_REPORT);

    assign DEC_INPUT_LLR    = llr_buf_q;
    assign DEC_INPUT_SYMBOL = ref_buf_q;
    assign RES_SYM_ERR      = res_sym_q;
    assign RES_FRAME_ERR    = res_ferr_q;
    assign RES_TIMEOUT      = res_tmo_q;
    assign FRAME_CNT        = frame_cnt_q;
    assign FAIL_CNT         = fail_cnt_q;

    // DEC_READY is registered once before edge detection, so a pre-existing high level never counts.
    assign rdy_edge = rdy_s_q & ~rdy_p_q;

    // beat_q doubles as the load beat index and the compare slice index.
    assign llr_base = 32'(beat_q) * BEAT_LLR_W;
    assign ref_base = 32'(beat_q) * BEAT_REF_W;
    assign cap_beat = cap_q[ref_base +: BEAT_REF_W];
    assign ref_beat = ref_buf_q[ref_base +: BEAT_REF_W];

    always_comb begin
        lane_mis = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (cap_beat[l*SYMBOL_BIT +: SYMBOL_BIT] != ref_beat[l*SYMBOL_BIT +: SYMBOL_BIT])
                lane_mis = lane_mis + SE_W'(1);
        end
    end

    assign acc_sum = acc_q + lane_mis;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        tmo_d      = tmo_q;
        acc_d      = acc_q;
        res_sym_d  = res_sym_q;
        res_ferr_d = res_ferr_q;
        res_tmo_d  = res_tmo_q;
        cap_en     = 1'b0;
        unique case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_LAUNCH: begin
                tmo_d   = '0;
                acc_d   = '0;
                beat_d  = '0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (rdy_edge) begin
                    cap_en  = 1'b1;
                    state_d = S_COMPARE;
                end else if (tmo_q == TMO_LAST) begin
                    res_sym_d  = SE_ALL;
                    res_ferr_d = 1'b1;
                    res_tmo_d  = 1'b1;
                    state_d    = S_REPORT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_COMPARE: begin
                acc_d = acc_sum;
                if (beat_q == INFO_LAST) begin
                    beat_d     = '0;
                    res_sym_d  = acc_sum;
                    res_ferr_d = (acc_sum != '0);
                    res_tmo_d  = 1'b0;
                    state_d    = S_REPORT;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        if (CLR_STATS) begin
            frame_cnt_d = '0;
            fail_cnt_d  = '0;
        end else if (state_q == S_REPORT) begin
            if (frame_cnt_q != '1)
                frame_cnt_d = frame_cnt_q + CNT_BIT'(1);
            if (res_ferr_q && (fail_cnt_q != '1))
                fail_cnt_d = fail_cnt_q + CNT_BIT'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            tmo_q       <= '0;
            acc_q       <= '0;
            res_sym_q   <= '0;
            res_ferr_q  <= 1'b0;
            res_tmo_q   <= 1'b0;
            frame_cnt_q <= '0;
            fail_cnt_q  <= '0;
            rdy_s_q     <= 1'b0;
            rdy_p_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            acc_q       <= acc_d;
            res_sym_q   <= res_sym_d;
            res_ferr_q  <= res_ferr_d;
            res_tmo_q   <= res_tmo_d;
            frame_cnt_q <= frame_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            rdy_s_q     <= DEC_READY;
            rdy_p_q     <= rdy_s_q;
        end
    end

    // Frame and capture buffers carry no reset; their contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            llr_buf_q[llr_base +: BEAT_LLR_W] <= IN_LLR;
            if (beat_q <= INFO_LAST)
                ref_buf_q[ref_base +: BEAT_REF_W] <= IN_REF;
        end
        if (cap_en)
            cap_q <= DEC_OUTPUT_SYMBOL;
    end

endmodule
